ps2_rx_fifo: RTL
================

// Module: ps2_rx_fifo
// PURPOSE
//  Parametrised PS/2 device-to-host receiver with a show-ahead scancode FIFO.
//  - Synchronises ps2_clk/ps2_data and deframes 11-bit frames (start, 8 data LSB-first, odd parity, stop).
//  - Checks every frame; times out stalled frames; buffers good bytes for a valid/ready consumer.
//  - Sits between the PS/2 pins and the keyboard/UART-style consumer in the NPC SoC.
// PARAMETERS
//  FIFO_DEPTH      8     entries, power of 2, >=2
//  SYNC_STAGES     3     synchroniser flops on ps2_clk and ps2_data, >=2
//  TIMEOUT_CYCLES  4096  clk cycles with no ps2_clk falling edge inside a frame before abort; >=2 PS/2 bit periods
// PORTS
//  clk           in   1                    system clock
//  resetn        in   1                    synchronous, active-low reset
//  ps2_clk       in   1                    raw PS/2 clock, asynchronous
//  ps2_data      in   1                    raw PS/2 data, asynchronous
//  out_valid     out  1                    FIFO not empty
//  out_ready     in   1                    consumer accepts head entry
//  out_data      out  8                    head scancode
//  out_break     out  1                    head entry is a break code (macro only, else 0)
//  fifo_count    out  $clog2(FIFO_DEPTH)+1 occupied entries
//  err_parity    out  1                    1-cycle pulse: parity failure
//  err_frame     out  1                    1-cycle pulse: bad stop bit or timeout
//  err_overflow  out  1                    1-cycle pulse: good byte dropped, FIFO full
// BEHAVIOUR
//  Reset: sync flops=1, FSM=IDLE, bit count=0, FIFO empty; out_valid, out_data, out_break, fifo_count, err_* = 0.
//  Sampling:
//   - Falling edge = synced ps2_clk previous 1, current 0.
//   - ps2_data sampled from its final sync stage in the same cycle.
//  FSM IDLE:
//   - On edge with data=0 (start): go to RECV, bit count=1, timeout counter=0.
//   - On edge with data=1: stay IDLE, no error (glitch).
//  FSM RECV:
//   - Bits 1..8 shift into the data register LSB-first; bit 9 = parity; bit 10 = stop.
//   - Timeout counter increments each cycle and clears on each edge.
//   - Counter reaching TIMEOUT_CYCLES-1: go to IDLE, err_frame pulse, partial frame discarded.
//  Frame check on bit-10 edge, then always return to IDLE:
//   - ^{data,parity}==0: err_parity pulse, no push.
//   - Else stop==0: err_frame pulse, no push.
//   - Else push. Both faults: err_parity only.
//  Latency: push is registered in the bit-10 edge cycle; out_valid/fifo_count update on the next clk edge.
//  FIFO:
//   - Show-ahead: out_data/out_break = head whenever out_valid=1.
//   - Pop when out_valid & out_ready; out_ready ignored when empty.
//   - Push when full and no pop: byte dropped, err_overflow pulse, contents unchanged.
//   - Push when full with pop in same cycle: both occur, fifo_count unchanged, no error.
//   - Pointers wrap modulo FIFO_DEPTH; fifo_count never exceeds FIFO_DEPTH.
//  Reset mid-frame or mid-pop: partial frame and all FIFO contents discarded.
// CONFIGURATION
//  PS2_BREAK_DECODE_EN defined:
//   - FIFO is 9 bits wide.
//   - Good byte 0xF0 is not pushed; it sets break_pending.
//   - Next good byte is pushed with out_break=1 and clears break_pending.
//   - Any err_parity/err_frame clears break_pending. Reset clears it.
//   - Overflow drop of the following byte still clears it.
//  PS2_BREAK_DECODE_EN undefined:
//   - FIFO is 8 bits wide; every good byte, 0xF0 included, is pushed raw.
//   - out_break tied 0.
// TESTING (bench ps2_clk half-period 8 clk unless stated)
//  1. Send frame 0x1C (bits 0,0,0,1,1,1,0,0,0,0,1) -> out_valid 1 cycle after bit-10 edge, out_data=0x1C, fifo_count=1; pop -> count 0.
//  2. Send 0x1C with parity=1 -> err_parity one pulse, fifo_count stays 0. Send with stop=0 -> err_frame one pulse, no push.
//  3. FIFO_DEPTH=8, out_ready=0, send 0x01..0x09 -> fifo_count=8, one err_overflow on 0x09; drain reads 0x01..0x08 in order.
//  4. Full FIFO, out_ready=1 held across a push cycle -> no err_overflow, count stays 8, tail=new byte.
//  5. Send start+4 bits, hold ps2_clk=1 for TIMEOUT_CYCLES -> err_frame pulse, no push; then full frame 0x32 -> out_data=0x32.
//  6. Send 0xF0 then 0x1C:
//     - Macro defined -> one entry {out_break=1, 0x1C}.
//     - Macro undefined -> entries 0xF0 then 0x1C.
//     - resetn=0 after bit 5 of a later frame -> FIFO empty, next frame decodes cleanly.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronise, deframe, check and buffer scancodes in a show-ahead FIFO.
// Optional break-code folding (0xF0 prefix -> out_break flag) is enabled by defining PS2_BREAK_DECODE_EN.
module ps2_rx_fifo #(
   parameter int FIFO_DEPTH     = 8,
   parameter int SYNC_STAGES    = 3,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          ps2_clk,
   input  logic                          ps2_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [7:0]                    out_data,
   output logic                          out_break,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          err_parity,
   output logic                          err_frame,
   output logic                          err_overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
`ifdef PS2_BREAK_DECODE_EN
   localparam int FW = 9;
`else
   localparam int FW = 8;
`endif

   typedef enum logic {IDLE, RECV} state_t;

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] dat_sync;
   logic                   clk_prev;
   logic                   fall;
   logic                   bit_in;

   state_t        state, state_nxt;
   logic [3:0]    bit_cnt, bit_cnt_nxt;
   logic [7:0]    shreg, shreg_nxt;
   logic          par_bit, par_bit_nxt;
   logic [TW-1:0] to_cnt, to_cnt_nxt;
   logic          byte_ok;
   logic          par_fail;
   logic          frm_fail;

   logic          push;
   logic [FW-1:0] push_word;
   logic          brk_pend;

   logic [FW-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   count;
   logic          full;
   logic          pop;
   logic          wr_en;
   logic [FW-1:0] head;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         clk_sync <= '1;
         dat_sync <= '1;
         clk_prev <= 1'b1;
      end else begin
         clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
         dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
         clk_prev <= clk_sync[SYNC_STAGES-1];
      end
   end

   assign fall   = clk_prev & ~clk_sync[SYNC_STAGES-1];
   assign bit_in = dat_sync[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state   <= IDLE;
         bit_cnt <= '0;
         shreg   <= '0;
         par_bit <= 1'b0;
         to_cnt  <= '0;
      end else begin
         state   <= state_nxt;
         bit_cnt <= bit_cnt_nxt;
         shreg   <= shreg_nxt;
         par_bit <= par_bit_nxt;
         to_cnt  <= to_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      bit_cnt_nxt = bit_cnt;
      shreg_nxt   = shreg;
      par_bit_nxt = par_bit;
      to_cnt_nxt  = to_cnt;
      byte_ok     = 1'b0;
      par_fail    = 1'b0;
      frm_fail    = 1'b0;
      case (state)
         IDLE: begin
            if (fall && !bit_in) begin
               state_nxt   = RECV;
               bit_cnt_nxt = 4'd1;
               to_cnt_nxt  = '0;
            end
         end
         RECV: begin
            if (fall) begin
               to_cnt_nxt  = '0;
               bit_cnt_nxt = bit_cnt + 4'd1;
               if (bit_cnt <= 4'd8) begin
                  shreg_nxt = {bit_in, shreg[7:1]};
               end else if (bit_cnt == 4'd9) begin
                  par_bit_nxt = bit_in;
               end else begin
                  // Stop bit: parity fault takes precedence over a bad stop bit.
                  state_nxt   = IDLE;
                  bit_cnt_nxt = '0;
                  if (~^{shreg, par_bit})
                     par_fail = 1'b1;
                  else if (!bit_in)
                     frm_fail = 1'b1;
                  else
                     byte_ok = 1'b1;
               end
            end else if (to_cnt == TO_LAST) begin
               state_nxt   = IDLE;
               bit_cnt_nxt = '0;
               frm_fail    = 1'b1;
            end else begin
               to_cnt_nxt = to_cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef PS2_BREAK_DECODE_EN
   assign push      = byte_ok && (shreg != 8'hF0);
   assign push_word = {brk_pend, shreg};

   // The prefix is consumed by whatever good byte follows, even if that byte is dropped on overflow.
   always_ff @(posedge clk) begin
      if (!resetn)
         brk_pend <= 1'b0;
      else if (par_fail || frm_fail)
         brk_pend <= 1'b0;
      else if (byte_ok)
         brk_pend <= (shreg == 8'hF0);
   end
`else
   assign push      = byte_ok;
   assign push_word = shreg;
   assign brk_pend  = 1'b0;
`endif

   assign out_valid = (count != '0);
   assign full      = (count == FULL_CNT);
   assign pop       = out_valid & out_ready;
   assign wr_en     = push & (~full | pop);
   assign head      = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!resetn) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // When full with a pop, wr_ptr == rd_ptr: the head is read before this edge overwrites it.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr] <= push_word;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         err_parity   <= 1'b0;
         err_frame    <= 1'b0;
         err_overflow <= 1'b0;
      end else begin
         err_parity   <= par_fail;
         err_frame    <= frm_fail;
         err_overflow <= push & full & ~pop;
      end
   end

   assign out_data   = out_valid ? head[7:0] : 8'h00;
`ifdef PS2_BREAK_DECODE_EN
   assign out_break  = out_valid & head[8];
`else
   assign out_break  = brk_pend;
`endif
   assign fifo_count = count;

endmodule
